// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and flag-source encoding shared by the ALU, its sources and benches
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_MAX = 4'd11;
  localparam logic [3:0] OP_MIN = 4'd12;
  localparam logic [3:0] OP_PASSA = 4'd13;
  localparam logic [3:0] OP_PASSB = 4'd14;
  localparam logic [3:0] OP_ILL = 4'd15;
  typedef enum logic [1:0] {FS_NONE, FS_OVF, FS_CMP, FS_ILL} flag_src_e;
  function automatic flag_src_e flag_src(input logic [3:0] op);
    return (op == OP_ADD || op == OP_SUB || op == OP_MUL) ? FS_OVF :
           (op == OP_SLT) ? FS_CMP : (op == OP_ILL) ? FS_ILL : FS_NONE;
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational signed ALU with overflow flag and optional saturation
module alu_core import alu_pkg::*; #(
  parameter int data_width = 32,
  parameter bit sat_en = 1'b0
) (
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic [3:0]            op,
  output logic [data_width-1:0] r,
  output logic                  flag,
  output logic                  is_arith
);
  localparam int SW = $clog2(data_width);
  localparam int M = data_width - 1;
  logic [data_width-1:0] sum, diff, raw, smax, smin;
  logic [2*data_width-1:0] prod;
  logic [SW-1:0] sh;
  logic slt, ovf, neg;
  flag_src_e fs;
  assign sum = a + b;
  assign diff = a - b;
  assign prod = {{data_width{a[M]}}, a} * {{data_width{b[M]}}, b};
  assign sh = b[SW-1:0];
  assign slt = $signed(a) < $signed(b);
  assign fs = flag_src(op);
  assign smax = {1'b0, {M{1'b1}}};
  assign smin = {1'b1, {M{1'b0}}};
  // wrapping result for each opcode; illegal opcode yields zero
  always_comb begin
    raw = '0;
    case (op)
      OP_ADD: raw = sum;
      OP_SUB: raw = diff;
      OP_AND: raw = a & b;
      OP_OR: raw = a | b;
      OP_XOR: raw = a ^ b;
      OP_NOT: raw = ~a;
      OP_SLL: raw = a << sh;
      OP_SRL: raw = a >> sh;
      OP_SRA: raw = $signed(a) >>> sh;
      OP_SLT: raw = {{M{1'b0}}, slt};
      OP_MUL: raw = prod[M:0];
      OP_MAX: raw = slt ? b : a;
      OP_MIN: raw = slt ? a : b;
      OP_PASSA: raw = a;
      OP_PASSB: raw = b;
      default: raw = '0;
    endcase
  end
  // overflow detection, clamp toward the sign of the true result, flag selection
  always_comb begin
    ovf = op == OP_ADD ? (a[M] == b[M] && sum[M] != a[M]) :
          op == OP_SUB ? (a[M] != b[M] && diff[M] != a[M]) :
          !(&prod[2*data_width-1:M] || ~|prod[2*data_width-1:M]);
    neg = op == OP_MUL ? prod[2*data_width-1] : a[M];
    r = (sat_en && fs == FS_OVF && ovf) ? (neg ? smin : smax) : raw;
    flag = fs == FS_OVF ? ovf : fs == FS_CMP ? raw[0] : fs == FS_ILL;
    is_arith = fs == FS_OVF;
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready pipelined ALU with whole-pipe stall and overflow event counter
module alu_pipe import alu_pkg::*; #(
  parameter int data_width = 32,
  parameter int stages = 2,
  parameter bit sat_en = 1'b0,
  parameter int cnt_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] A,
  input  logic [data_width-1:0] B,
  input  logic [3:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] R,
  output logic                  flag,
  output logic [cnt_width-1:0]  ovf_cnt
);
  localparam int L = stages - 1;
  logic [stages-1:0] vld_q, vld_d, flg_q, flg_d, ari_q, ari_d;
  logic [stages-1:0][data_width-1:0] res_q, res_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [data_width-1:0] core_r;
  logic core_flag, core_arith, stall;
  alu_core #(.data_width(data_width), .sat_en(sat_en)) u_core (
    .a(A),
    .b(B),
    .op(op),
    .r(core_r),
    .flag(core_flag),
    .is_arith(core_arith)
  );
  assign stall = vld_q[L] && !out_ready;
  assign in_ready = !stall;
  assign out_valid = vld_q[L];
  assign R = res_q[L];
  assign flag = flg_q[L];
  assign ovf_cnt = cnt_q;
  // advance every stage, bubbles included, unless the output is stalled
  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    flg_d = flg_q;
    ari_d = ari_q;
    if (!stall) begin
      for (int i = L; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
        flg_d[i] = flg_q[i-1];
        ari_d[i] = ari_q[i-1];
      end
      vld_d[0] = in_valid;
      res_d[0] = core_r;
      flg_d[0] = core_flag;
      ari_d[0] = core_arith;
    end
  end
  // count delivered ADD/SUB/MUL overflows, sticking at all-ones
  always_comb cnt_d = (out_valid && out_ready && flag && ari_q[L] && !(&cnt_q)) ? cnt_q + cnt_width'(1) : cnt_q;
  // state registers, reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      res_q <= '0;
      flg_q <= '0;
      ari_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      flg_q <= flg_d;
      ari_q <= ari_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
